// File: rtl/bp_nonsynth_commit_aligner.sv
// Cosim commit/writeback aligner: buffers commits and per-port writebacks, emits one aligned retire record per handshake.
// Optional trace output is enabled by defining BP_COMMIT_ALIGNER_TRACE_EN.
module bp_nonsynth_commit_aligner #(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int num_wb_p         = 2,
    parameter int commit_els_p     = 8,
    parameter int wb_els_p         = 4,
    parameter int timeout_p        = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   en_i,
    input  logic                                   commit_v_i,
    input  logic [vaddr_width_p-1:0]               commit_pc_i,
    input  logic [instr_width_p-1:0]               commit_instr_i,
    input  logic [num_wb_p-1:0]                    commit_wb_sel_i,
    input  logic                                   interrupt_v_i,
    input  logic [dword_width_p-1:0]               cause_i,
    input  logic [num_wb_p-1:0]                    wb_v_i,
    input  logic [num_wb_p*reg_addr_width_p-1:0]   wb_addr_i,
    input  logic [num_wb_p*dword_width_p-1:0]      wb_data_i,
    output logic                                   out_v_o,
    output logic                                   out_trap_o,
    output logic [vaddr_width_p-1:0]               out_pc_o,
    output logic [instr_width_p-1:0]               out_instr_o,
    output logic [reg_addr_width_p-1:0]            out_rd_addr_o,
    output logic [dword_width_p-1:0]               out_wdata_o,
    input  logic                                   out_yumi_i,
    output logic                                   overflow_o,
    output logic                                   timeout_o,
    output logic [31:0]                            retire_cnt_o
);

    localparam int cptr_w_lp = $clog2(commit_els_p);
    localparam int wptr_w_lp = $clog2(wb_els_p);
    localparam int wait_w_lp = $clog2(timeout_p + 1);
    localparam logic [cptr_w_lp:0]   commit_full_lp = (cptr_w_lp+1)'(commit_els_p);
    localparam logic [wptr_w_lp:0]   wb_full_lp     = (wptr_w_lp+1)'(wb_els_p);
    localparam logic [wait_w_lp-1:0] wait_max_lp    = wait_w_lp'(timeout_p);

    typedef struct packed {
        logic                      trap;
        logic [vaddr_width_p-1:0]  pc;
        logic [instr_width_p-1:0]  instr;
        logic [num_wb_p-1:0]       sel;
        logic [dword_width_p-1:0]  cause;
    } commit_entry_t;

    typedef enum logic [1:0] {e_idle = 2'd0, e_wait = 2'd1, e_ready = 2'd2} state_e;

    function automatic logic [num_wb_p-1:0] lowest_bit(input logic [num_wb_p-1:0] v);
        lowest_bit = '0;
        for (int k = num_wb_p - 1; k >= 0; k--) begin
            if (v[k]) begin
                lowest_bit    = '0;
                lowest_bit[k] = 1'b1;
            end
        end
    endfunction

    commit_entry_t                          commit_mem_q [commit_els_p];
    logic [cptr_w_lp-1:0]                   commit_rd_q, commit_wr_q, commit_rd_d_s;
    logic [cptr_w_lp:0]                     commit_cnt_q, commit_cnt_d, commit_rem_s;
    commit_entry_t                          commit_head_s, commit_new_s, next_head_s;
    logic                                   commit_push_s, commit_wr_s, commit_drop_s, retire_s;

    logic [reg_addr_width_p-1:0]            wb_addr_mem_q [num_wb_p][wb_els_p];
    logic [dword_width_p-1:0]               wb_data_mem_q [num_wb_p][wb_els_p];
    logic [num_wb_p-1:0][wptr_w_lp-1:0]     wb_rd_q, wb_wr_q;
    logic [num_wb_p-1:0][wptr_w_lp:0]       wb_cnt_q, wb_cnt_d;
    logic [num_wb_p-1:0]                    wb_push_s, wb_pop_s, wb_wr_s, wb_drop_s, wb_nonempty_d_s;

    state_e                                 state_q, state_d;
    logic [wait_w_lp-1:0]                   wait_cnt_q, wait_cnt_d;
    logic                                   overflow_q, overflow_d, timeout_q, timeout_d;
    logic [31:0]                            retire_cnt_q;

    assign retire_s      = out_yumi_i & (state_q == e_ready);
    assign commit_push_s = en_i & (commit_v_i | interrupt_v_i);
    assign commit_wr_s   = commit_push_s & ((commit_cnt_q != commit_full_lp) | retire_s);
    assign commit_drop_s = commit_push_s & ~commit_wr_s;
    assign commit_cnt_d  = commit_cnt_q + (cptr_w_lp+1)'(commit_wr_s) - (cptr_w_lp+1)'(retire_s);
    assign commit_head_s = commit_mem_q[commit_rd_q];
    assign commit_rd_d_s = commit_rd_q + cptr_w_lp'(retire_s);
    assign commit_rem_s  = commit_cnt_q - (cptr_w_lp+1)'(retire_s);

    // Trap entries carry no writeback; multi-hot selects collapse to their lowest port.
    always_comb begin
        commit_new_s.trap  = interrupt_v_i;
        commit_new_s.pc    = commit_pc_i;
        commit_new_s.instr = commit_instr_i;
        commit_new_s.sel   = interrupt_v_i ? '0 : lowest_bit(commit_wb_sel_i);
        commit_new_s.cause = cause_i;
    end

    // Per-port writeback FIFO control, popped alongside the commit that consumes it.
    always_comb begin
        wb_push_s       = '0;
        wb_pop_s        = '0;
        wb_wr_s         = '0;
        wb_drop_s       = '0;
        wb_nonempty_d_s = '0;
        wb_cnt_d        = wb_cnt_q;
        for (int k = 0; k < num_wb_p; k++) begin
            wb_push_s[k]       = en_i & wb_v_i[k];
            wb_pop_s[k]        = retire_s & commit_head_s.sel[k];
            wb_wr_s[k]         = wb_push_s[k] & ((wb_cnt_q[k] != wb_full_lp) | wb_pop_s[k]);
            wb_drop_s[k]       = wb_push_s[k] & ~wb_wr_s[k];
            wb_cnt_d[k]        = wb_cnt_q[k] + (wptr_w_lp+1)'(wb_wr_s[k]) - (wptr_w_lp+1)'(wb_pop_s[k]);
            wb_nonempty_d_s[k] = (wb_cnt_d[k] != '0);
        end
    end

    // The head seen next cycle is the incoming entry when no older entry survives this cycle.
    always_comb begin
        if (commit_rem_s == '0) begin
            next_head_s = commit_new_s;
        end else begin
            next_head_s = commit_mem_q[commit_rd_d_s];
        end
    end

    // Next-state: classify the head that will be present after this edge.
    always_comb begin
        state_d = e_idle;
        if (commit_cnt_d == '0) begin
            state_d = e_idle;
        end else if (next_head_s.trap || (next_head_s.sel == '0)
                     || ((next_head_s.sel & wb_nonempty_d_s) != '0)) begin
            state_d = e_ready;
        end else begin
            state_d = e_wait;
        end
    end

    // Wait counter, sticky flags.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (retire_s) begin
            wait_cnt_d = '0;
        end else if ((state_q == e_wait) && (wait_cnt_q != wait_max_lp)) begin
            wait_cnt_d = wait_cnt_q + wait_w_lp'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        overflow_d = overflow_q | commit_drop_s | (|wb_drop_s);
        timeout_d  = timeout_q | (wait_cnt_d == wait_max_lp);
    end

    // Record fields come straight from the FIFO heads and are forced to zero unless valid.
    always_comb begin
        out_v_o       = 1'b0;
        out_trap_o    = 1'b0;
        out_pc_o      = '0;
        out_instr_o   = '0;
        out_rd_addr_o = '0;
        out_wdata_o   = '0;
        case (state_q)
            e_ready: begin
                out_v_o = 1'b1;
                if (commit_head_s.trap) begin
                    out_trap_o  = 1'b1;
                    out_wdata_o = commit_head_s.cause;
                end else begin
                    out_pc_o    = commit_head_s.pc;
                    out_instr_o = commit_head_s.instr;
                    for (int k = 0; k < num_wb_p; k++) begin
                        if (commit_head_s.sel[k]) begin
                            out_rd_addr_o = wb_addr_mem_q[k][wb_rd_q[k]];
                            out_wdata_o   = wb_data_mem_q[k][wb_rd_q[k]];
                        end
                    end
                end
            end
            default: begin
                out_v_o = 1'b0;
            end
        endcase
    end

    // FIFO storage arrays; contents are qualified by the counts so they need no reset.
    always_ff @(posedge clk_i) begin
        if (commit_wr_s) begin
            commit_mem_q[commit_wr_q] <= commit_new_s;
        end
        for (int k = 0; k < num_wb_p; k++) begin
            if (wb_wr_s[k]) begin
                wb_addr_mem_q[k][wb_wr_q[k]] <= wb_addr_i[k*reg_addr_width_p +: reg_addr_width_p];
                wb_data_mem_q[k][wb_wr_q[k]] <= wb_data_i[k*dword_width_p +: dword_width_p];
            end
        end
    end

    // Pointers, counts, FSM state and status registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            commit_rd_q  <= '0;
            commit_wr_q  <= '0;
            commit_cnt_q <= '0;
            wb_rd_q      <= '0;
            wb_wr_q      <= '0;
            wb_cnt_q     <= '0;
            state_q      <= e_idle;
            wait_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            commit_rd_q  <= commit_rd_d_s;
            commit_wr_q  <= commit_wr_q + cptr_w_lp'(commit_wr_s);
            commit_cnt_q <= commit_cnt_d;
            for (int k = 0; k < num_wb_p; k++) begin
                wb_rd_q[k] <= wb_rd_q[k] + wptr_w_lp'(wb_pop_s[k]);
                wb_wr_q[k] <= wb_wr_q[k] + wptr_w_lp'(wb_wr_s[k]);
            end
            wb_cnt_q     <= wb_cnt_d;
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            if (retire_s && !commit_head_s.trap && (retire_cnt_q != 32'hFFFF_FFFF)) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end else begin
                retire_cnt_q <= retire_cnt_q;
            end
        end
    end

    assign overflow_o   = overflow_q;
    assign timeout_o    = timeout_q;
    assign retire_cnt_o = retire_cnt_q;

`ifdef BP_COMMIT_ALIGNER_TRACE_EN
    // Retire trace and first-occurrence error reporting.
    always @(posedge clk_i) begin
        if (reset_i) begin
            if (retire_s && out_trap_o) begin
                $display("[ALIGN] trap cause=%h", out_wdata_o);
            end else if (retire_s) begin
                $display("[ALIGN] pc=%h instr=%h rd=%d data=%h", out_pc_o, out_instr_o, out_rd_addr_o, out_wdata_o);
            end
            if (overflow_d && !overflow_q) begin
                $error("[ALIGN] FIFO overflow");
            end
            if (timeout_d && !timeout_q) begin
                $error("[ALIGN] head wait timeout");
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_nonsynth_commit_aligner.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based retire model.
module tb_bp_nonsynth_commit_aligner;

    localparam int VA = 39, IW = 32, DW = 64, RW = 5, NWB = 2, CE = 8, WE = 4, TO = 4;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              en_i, commit_v_i, interrupt_v_i, out_yumi_i;
    logic [VA-1:0]     commit_pc_i;
    logic [IW-1:0]     commit_instr_i;
    logic [NWB-1:0]    commit_wb_sel_i, wb_v_i;
    logic [DW-1:0]     cause_i;
    logic [NWB*RW-1:0] wb_addr_i;
    logic [NWB*DW-1:0] wb_data_i;
    logic              out_v_o, out_trap_o, overflow_o, timeout_o;
    logic [VA-1:0]     out_pc_o;
    logic [IW-1:0]     out_instr_o;
    logic [RW-1:0]     out_rd_addr_o;
    logic [DW-1:0]     out_wdata_o;
    logic [31:0]       retire_cnt_o;

    bp_nonsynth_commit_aligner #(
        .vaddr_width_p(VA), .instr_width_p(IW), .dword_width_p(DW), .reg_addr_width_p(RW),
        .num_wb_p(NWB), .commit_els_p(CE), .wb_els_p(WE), .timeout_p(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .commit_v_i(commit_v_i),
        .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i), .commit_wb_sel_i(commit_wb_sel_i),
        .interrupt_v_i(interrupt_v_i), .cause_i(cause_i), .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .out_v_o(out_v_o), .out_trap_o(out_trap_o), .out_pc_o(out_pc_o),
        .out_instr_o(out_instr_o), .out_rd_addr_o(out_rd_addr_o), .out_wdata_o(out_wdata_o),
        .out_yumi_i(out_yumi_i), .overflow_o(overflow_o), .timeout_o(timeout_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { bit trap; logic [VA-1:0] pc; logic [IW-1:0] instr; int idx; logic [DW-1:0] cause; } mcommit_t;
    typedef struct { logic [RW-1:0] addr; logic [DW-1:0] data; } mwb_t;

    mcommit_t    cq[$];
    mwb_t        wq0[$], wq1[$];
    int          m_wait;
    bit          m_ovf, m_tmo, yumi_req;
    logic [31:0] m_cnt;
    int          vec_cnt = 0, miscmp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int wq_size(input int k);
        return (k == 0) ? wq0.size() : wq1.size();
    endfunction

    function automatic mwb_t wq_head(input int k);
        return (k == 0) ? wq0[0] : wq1[0];
    endfunction

    task automatic model_clear();
        cq.delete(); wq0.delete(); wq1.delete();
        m_wait = 0; m_ovf = 0; m_tmo = 0; m_cnt = 32'd0;
    endtask

    task automatic idle();
        en_i = 1'b1; commit_v_i = 1'b0; interrupt_v_i = 1'b0; commit_wb_sel_i = '0;
        commit_pc_i = '0; commit_instr_i = '0; cause_i = '0; wb_v_i = '0;
        wb_addr_i = '0; wb_data_i = '0; yumi_req = 1'b0;
    endtask

    // One cycle: compare DUT against the model, choose yumi, advance the model, move to the next negedge.
    task automatic step();
        bit ev, waiting;
        logic etrap;
        logic [VA-1:0] epc;
        logic [IW-1:0] einstr;
        logic [RW-1:0] erd;
        logic [DW-1:0] ewd;
        mcommit_t h, ne;
        mwb_t w, nw;
        ev = 0; etrap = 0; epc = '0; einstr = '0; erd = '0; ewd = '0;
        if (cq.size() > 0) begin
            h = cq[0];
            if (h.trap) begin
                ev = 1; etrap = 1; ewd = h.cause;
            end else if (h.idx < 0) begin
                ev = 1; epc = h.pc; einstr = h.instr;
            end else if (wq_size(h.idx) > 0) begin
                ev = 1; epc = h.pc; einstr = h.instr;
                w = wq_head(h.idx); erd = w.addr; ewd = w.data;
            end
        end
        check("out_v", out_v_o, ev);
        check("out_trap", out_trap_o, etrap);
        check("out_pc", out_pc_o, epc);
        check("out_instr", out_instr_o, einstr);
        check("out_rd", out_rd_addr_o, erd);
        check("out_wdata", out_wdata_o, ewd);
        check("overflow", overflow_o, m_ovf);
        check("timeout", timeout_o, m_tmo);
        check("retire_cnt", retire_cnt_o, m_cnt);
        out_yumi_i = yumi_req & ev;
        waiting = (cq.size() > 0) && !ev;
        if (out_yumi_i) begin
            h = cq.pop_front();
            if (!h.trap) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (h.idx == 0) void'(wq0.pop_front());
                else if (h.idx == 1) void'(wq1.pop_front());
            end
            m_wait = 0;
        end else if (waiting && m_wait < TO) begin
            m_wait++;
            if (m_wait == TO) m_tmo = 1;
        end
        if (en_i && (commit_v_i || interrupt_v_i)) begin
            ne.trap = interrupt_v_i; ne.pc = commit_pc_i; ne.instr = commit_instr_i; ne.cause = cause_i;
            ne.idx = interrupt_v_i ? -1 : commit_wb_sel_i[0] ? 0 : commit_wb_sel_i[1] ? 1 : -1;
            if (cq.size() < CE) cq.push_back(ne); else m_ovf = 1;
        end
        if (en_i && wb_v_i[0]) begin
            nw.addr = wb_addr_i[RW-1:0]; nw.data = wb_data_i[DW-1:0];
            if (wq0.size() < WE) wq0.push_back(nw); else m_ovf = 1;
        end
        if (en_i && wb_v_i[1]) begin
            nw.addr = wb_addr_i[2*RW-1:RW]; nw.data = wb_data_i[2*DW-1:DW];
            if (wq1.size() < WE) wq1.push_back(nw); else m_ovf = 1;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        out_yumi_i = 1'b0;
        reset_i = 1'b0;
        model_clear();
        @(negedge clk_i);
        check("rst_v", out_v_o, 1'b0);
        check("rst_cnt", retire_cnt_o, 32'd0);
        reset_i = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        idle();
        yumi_req = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (cq.size() == 0) break;
            step();
        end
        check("drain_empty", 64'(cq.size()), 64'd0);
        yumi_req = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        idle();
        out_yumi_i = 1'b0;
        @(negedge clk_i);
        do_reset();
        step();

        // Commit and int writeback in the same cycle.
        commit_v_i = 1'b1; commit_pc_i = 39'h0_8000_0000; commit_instr_i = 32'h0050_0293;
        commit_wb_sel_i = 2'b01; wb_v_i = 2'b01; wb_addr_i = {5'd0, 5'd5}; wb_data_i = {64'd0, 64'h1234};
        step();
        idle();
        check("t1_v", out_v_o, 1'b1);
        check("t1_rd", out_rd_addr_o, 5'd5);
        check("t1_wdata", out_wdata_o, 64'h1234);
        yumi_req = 1'b1; step(); yumi_req = 1'b0;
        check("t1_cnt", retire_cnt_o, 32'd1);
        step();

        // Interrupt wins over a simultaneous commit.
        commit_v_i = 1'b1; interrupt_v_i = 1'b1; cause_i = 64'h8000_0000_0000_0007;
        commit_pc_i = 39'h0_8000_0040; commit_wb_sel_i = 2'b01;
        step();
        idle();
        check("t3_trap", out_trap_o, 1'b1);
        check("t3_wdata", out_wdata_o, 64'h8000_0000_0000_0007);
        check("t3_pc", out_pc_o, 39'd0);
        yumi_req = 1'b1; step(); yumi_req = 1'b0;
        check("t3_cnt", retire_cnt_o, 32'd1);
        check("t3_single", out_v_o, 1'b0);

        // Writeback three cycles ahead of its commit.
        wb_v_i = 2'b01; wb_addr_i = {5'd0, 5'd7}; wb_data_i = {64'd0, 64'h55};
        step(); idle(); step(); step();
        commit_v_i = 1'b1; commit_pc_i = 39'h0_8000_0080; commit_wb_sel_i = 2'b01;
        step(); idle();
        check("t5_v", out_v_o, 1'b1);
        check("t5_rd", out_rd_addr_o, 5'd7);
        check("t5_wdata", out_wdata_o, 64'h55);
        yumi_req = 1'b1; step(); idle();
        commit_v_i = 1'b1; commit_pc_i = 39'h0_8000_0084; commit_wb_sel_i = 2'b01;
        step(); idle();
        check("t5_wb_empty", out_v_o, 1'b0);
        check("t5_ovf", overflow_o, 1'b0);
        wb_v_i = 2'b01; wb_addr_i = {5'd0, 5'd8}; wb_data_i = {64'd0, 64'h66};
        step();
        drain(10);

        // Nine commits into an eight-deep FIFO, then drain in order.
        for (int i = 0; i < 9; i++) begin
            commit_v_i = 1'b1; commit_pc_i = 39'(32'h9000_0000 + 32'(i * 4)); commit_instr_i = 32'(i);
            commit_wb_sel_i = 2'b00;
            step();
        end
        idle();
        check("t4_ovf", overflow_o, 1'b1);
        base = m_cnt;
        drain(20);
        check("t4_drained", retire_cnt_o, base + 32'd8);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            en_i            = ($urandom_range(0, 9) != 0);
            commit_v_i      = ($urandom_range(0, 1) == 1);
            interrupt_v_i   = ($urandom_range(0, 9) == 0);
            commit_wb_sel_i = 2'($urandom_range(0, 3));
            commit_pc_i     = 39'({$urandom(), $urandom()});
            commit_instr_i  = $urandom();
            cause_i         = {$urandom(), $urandom()};
            wb_v_i          = 2'($urandom_range(0, 3));
            wb_addr_i       = 10'($urandom());
            wb_data_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
            yumi_req        = ($urandom_range(0, 9) < 6);
            step();
        end
        drain(40);

        // Asynchronous reset while the head is waiting with three queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            commit_v_i = 1'b1; commit_pc_i = 39'(32'hA000_0000 + 32'(i * 4)); commit_wb_sel_i = 2'b10;
            step();
        end
        idle();
        check("t6_wait", out_v_o, 1'b0);
        reset_i = 1'b0;
        #1;
        check("t6_rst_v", out_v_o, 1'b0);
        check("t6_rst_pc", out_pc_o, 39'd0);
        check("t6_rst_ovf", overflow_o, 1'b0);
        check("t6_rst_cnt", retire_cnt_o, 32'd0);
        model_clear();
        @(negedge clk_i);
        reset_i = 1'b1;
        step();
        check("t6_idle", out_v_o, 1'b0);

        // fp writeback arrives late; timeout flag sticks across the retire.
        commit_v_i = 1'b1; commit_pc_i = 39'h0_8000_0100; commit_wb_sel_i = 2'b10;
        step(); idle();
        for (int i = 0; i < 6; i++) begin
            check("t2_wait", out_v_o, 1'b0);
            step();
        end
        wb_v_i = 2'b10; wb_addr_i = {5'd9, 5'd0}; wb_data_i = {64'hBEEF, 64'd0};
        step(); idle();
        check("t2_v", out_v_o, 1'b1);
        check("t2_wdata", out_wdata_o, 64'hBEEF);
        check("t2_tmo", timeout_o, 1'b1);
        yumi_req = 1'b1; step(); yumi_req = 1'b0;
        check("t2_tmo_sticky", timeout_o, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
